// File: rtl/div_param.sv
// Parametrised restoring divider: one quotient bit per clock, RISC-V M semantics.
// result = {remainder, quotient}; signed mode uses truncating division.
module div_param #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   op_A,
    input  logic [WIDTH-1:0]   op_B,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic             init_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_orig;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign sa      = signed_mode & op_A[WIDTH-1];
    assign sb      = signed_mode & op_B[WIDTH-1];
    assign a_mag_c = sa ? -op_A : op_A;
    assign b_mag_c = sb ? -op_B : op_B;

    // Shifted partial remainder needs one extra bit; the difference never does.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, b_mag};
    assign diff    = shifted[WIDTH-1:0] - b_mag;

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            init_q      <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            b_mag       <= '0;
            a_orig      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            result      <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            init_q <= init;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (init && !init_q) begin
                        quo    <= a_mag_c;
                        b_mag  <= b_mag_c;
                        a_orig <= op_A;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= (op_B == '0);
                        rem    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem <= fits ? diff : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result      <= dz ? {a_orig, {WIDTH{1'b1}}}
                                      : {r_fix, q_fix};
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Directed bench for div_param at WIDTH=16 and WIDTH=8.
// Expected results are queued at start and popped on done.
module tb_div_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        done;
    logic        busy;
    logic        dz;

    logic        init8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] res8;
    logic        done8;
    logic        busy8;
    logic        dz8;

    int checks   = 0;
    int failures = 0;
    int nd       = 0;
    int nd8      = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    div_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .init(init), .signed_mode(sm),
        .op_A(a), .op_B(b), .result(res), .done(done),
        .busy(busy), .div_by_zero(dz)
    );

    div_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .init(init8), .signed_mode(sm8),
        .op_A(a8), .op_B(b8), .result(res8), .done(done8),
        .busy(busy8), .div_by_zero(dz8)
    );

    always @(negedge clk) begin
        if (done === 1'b1) nd++;
        if (done8 === 1'b1) nd8++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start, holds init two cycles, then scrambles the operands.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic [31:0] er,
                          input logic ez);
        exp_t e;
        e.r = er;
        e.z = ez;
        sbq.push_back(e);
        a    = av;
        b    = bv;
        sm   = s;
        init = 1'b1;
        tick();
        chk("busy_start", 32'(busy), 32'd1);
        tick();
        init = 1'b0;
        a    = 16'($urandom);
        b    = 16'($urandom);
        sm   = ~s;
    endtask

    // cyc0 = number of edges already elapsed since the start edge.
    task automatic finish16(input string tag, input int cyc0);
        int   cyc;
        int   n0;
        exp_t e;
        cyc = cyc0;
        n0  = nd;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd17);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_res"}, res, e.r);
            chk({tag, "_dz"}, 32'(dz), 32'(e.z));
        end else begin
            chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
        end
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_res_hold"}, res, e.r);
        chk({tag, "_one_done"}, 32'(nd - n0), 32'd1);
    endtask

    initial begin
        int n0;
        int cyc;
        reset = 1'b0;
        init  = 1'b0;
        sm    = 1'b0;
        a     = '0;
        b     = '0;
        init8 = 1'b0;
        sm8   = 1'b0;
        a8    = '0;
        b8    = '0;

        tick();
        tick();
        chk("rst_res", res, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        launch(16'hC86C, 16'h00CA, 1'b0, 32'h0000_00FE, 1'b0);
        finish16("unsigned", 1);

        launch(16'hC86C, 16'h00CA, 1'b1, 32'hFFA8_FFBA, 1'b0);
        finish16("signed_neg", 1);

        launch(16'h0007, 16'hFFFE, 1'b1, 32'h0001_FFFD, 1'b0);
        finish16("signed_divneg", 1);

        launch(16'h1234, 16'h0000, 1'b0, 32'h1234_FFFF, 1'b1);
        finish16("dz_unsigned", 1);

        launch(16'h1234, 16'h0000, 1'b1, 32'h1234_FFFF, 1'b1);
        finish16("dz_signed", 1);

        launch(16'h8000, 16'hFFFF, 1'b1, 32'h0000_8000, 1'b0);
        finish16("overflow", 1);

        // Second rising edge while busy must be ignored.
        launch(16'hC86C, 16'h00CA, 1'b0, 32'h0000_00FE, 1'b0);
        tick();
        tick();
        a    = 16'h1234;
        b    = 16'h0000;
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        finish16("ignored", 5);
        n0 = nd;
        repeat (25) tick();
        chk("ignored_no_second", 32'(nd - n0), 32'd0);
        chk("ignored_dz", 32'(dz), 32'd0);

        // Reset during CALC aborts without a done pulse.
        launch(16'hC86C, 16'h00CA, 1'b1, 32'hFFA8_FFBA, 1'b0);
        repeat (4) tick();
        n0 = nd;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_dz", 32'(dz), 32'd0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (25) tick();
        chk("abort_no_done", 32'(nd - n0), 32'd0);
        chk("abort_res_hold", res, 32'd0);

        launch(16'h0007, 16'hFFFE, 1'b1, 32'h0001_FFFD, 1'b0);
        finish16("after_reset", 1);

        // WIDTH=8 instance.
        n0    = nd8;
        a8    = 8'hC8;
        b8    = 8'h0A;
        sm8   = 1'b0;
        init8 = 1'b1;
        tick();
        chk("w8_busy", 32'(busy8), 32'd1);
        tick();
        init8 = 1'b0;
        a8    = 8'hFF;
        b8    = 8'h00;
        cyc   = 1;
        while (done8 !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("w8_lat", 32'(cyc), 32'd9);
        chk("w8_res", 32'(res8), 32'h0000_0014);
        chk("w8_dz", 32'(dz8), 32'd0);
        tick();
        chk("w8_one_done", 32'(nd8 - n0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
